// File: rtl/guitar_pkg.sv
// Shared game-mode encodings, score FSM states and combo multiplier thresholds.
// Latency: n/a (declarations only). Backpressure: n/a.
// Imported by the score keeper and its combo counter.
package guitar_pkg;

    localparam logic [2:0] MODE_PLAY   = 3'b100;
    localparam logic [2:0] MODE_FINISH = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_DONE
    } score_state_t;

    // Combo value at which each multiplier step begins.
    localparam int MULT_TH_X2 = 4;
    localparam int MULT_TH_X3 = 8;
    localparam int MULT_TH_X4 = 16;

endpackage

// File: rtl/combo_counter.sv
// Saturating combo streak register plus a points multiplier (COMBO_MULT_EN selects the table, else 1).
// Latency: combo updates one cycle after inc/clr; mult is combinational from the current combo.
// Backpressure: none; inc/clr are accepted every cycle, clr wins over inc.
module combo_counter
    import guitar_pkg::*;
#(
    parameter int COMBO_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inc,
    input  logic               clr,
    output logic [COMBO_W-1:0] combo,
    output logic [2:0]         mult
);

    always_ff @(posedge clk) begin
        if (rst) begin
            combo <= '0;
        end else if (clr) begin
            combo <= '0;
        end else if (inc && (combo != {COMBO_W{1'b1}})) begin
            combo <= combo + 1'b1;
        end
    end

`ifdef COMBO_MULT_EN
    always_comb begin
        mult = 3'd1;
        if (int'(combo) >= MULT_TH_X4) begin
            mult = 3'd4;
        end else if (int'(combo) >= MULT_TH_X3) begin
            mult = 3'd3;
        end else if (int'(combo) >= MULT_TH_X2) begin
            mult = 3'd2;
        end
    end
`else
    assign mult = 3'd1;
`endif

endmodule

// File: rtl/score_keeper.sv
// Counts hits/misses during PLAY into a saturating score and combo; build option COMBO_MULT_EN scales points by combo.
// Latency: a judgement in cycle N shows on score/combo in cycle N+1; score_done pulses the cycle after PLAY->FINISH.
// Backpressure: none; hit/miss pulses are consumed or ignored in the cycle they arrive.
module score_keeper
    import guitar_pkg::*;
#(
    parameter int SCORE_W = 4,
    parameter int COMBO_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         mode,
    input  logic               hit,
    input  logic               miss,
    output logic [SCORE_W-1:0] score,
    output logic [COMBO_W-1:0] combo,
    output logic               score_done
);

    score_state_t       state;
    logic               mode_play;
    logic               mode_finish;
    logic               judge;
    logic               hit_j;
    logic               miss_j;
    logic               entry;
    logic [2:0]         mult;
    logic [SCORE_W:0]   sum;
    logic [SCORE_W-1:0] score_sat;

    assign mode_play   = (mode == MODE_PLAY);
    assign mode_finish = (mode == MODE_FINISH);

    // Entry cycle is still IDLE/DONE, so judgements only count once settled in PLAY.
    assign judge  = (state == S_PLAY) && mode_play;
    assign hit_j  = judge && hit && !miss;
    assign miss_j = judge && miss;
    assign entry  = (state != S_PLAY) && mode_play;

    combo_counter #(
        .COMBO_W(COMBO_W)
    ) u_combo (
        .clk   (clk),
        .rst   (rst),
        .inc   (hit_j),
        .clr   (miss_j || entry),
        .combo (combo),
        .mult  (mult)
    );

    // One extra bit catches overflow; clamp to all-ones.
    assign sum       = {1'b0, score} + (SCORE_W+1)'(mult);
    assign score_sat = sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            score      <= '0;
            score_done <= 1'b0;
        end else begin
            score_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (mode_play) begin
                        state <= S_PLAY;
                        score <= '0;
                    end
                end
                S_PLAY: begin
                    if (mode_finish) begin
                        state      <= S_DONE;
                        score_done <= 1'b1;
                    end else if (!mode_play) begin
                        state <= S_IDLE;
                    end else if (hit_j) begin
                        score <= score_sat;
                    end
                end
                S_DONE: begin
                    if (mode_play) begin
                        state <= S_PLAY;
                        score <= '0;
                    end else if (!mode_finish) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_score_keeper.sv
// Randomised scoreboard bench for score_keeper against an arithmetic reference model.
module tb_score_keeper;

    localparam int SCORE_W   = 4;
    localparam int COMBO_W   = 5;
    localparam int SCORE_MAX = 15;
    localparam int COMBO_MAX = 31;

    localparam logic [2:0] M_PLAY   = 3'b100;
    localparam logic [2:0] M_FINISH = 3'b101;
    localparam logic [2:0] M_IDLE   = 3'b000;

    logic               clk;
    logic               rst;
    logic [2:0]         mode;
    logic               hit;
    logic               miss;
    logic [SCORE_W-1:0] score;
    logic [COMBO_W-1:0] combo;
    logic               score_done;

    score_keeper #(
        .SCORE_W(SCORE_W),
        .COMBO_W(COMBO_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .hit        (hit),
        .miss       (miss),
        .score      (score),
        .combo      (combo),
        .score_done (score_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int score;
        int combo;
        bit done;
        int idx;
    } exp_t;

    exp_t exp_q[$];

    int vectors    = 0;
    int miscompares = 0;
    int step_idx   = 0;

    // Reference model: 0 = idle, 1 = playing, 2 = finished.
    int m_phase = 0;
    int m_score = 0;
    int m_combo = 0;
    bit m_done  = 0;

    function automatic int points(input int c);
`ifdef COMBO_MULT_EN
        if (c >= 16) return 4;
        if (c >= 8)  return 3;
        if (c >= 4)  return 2;
        return 1;
`else
        return 1;
`endif
    endfunction

    task automatic model_update(input bit r, input logic [2:0] md, input bit h, input bit ms);
        exp_t e;
        if (r) begin
            m_phase = 0;
            m_score = 0;
            m_combo = 0;
            m_done  = 0;
        end else begin
            m_done = (m_phase == 1) && (md == M_FINISH);
            if (md == M_PLAY && m_phase != 1) begin
                m_phase = 1;
                m_score = 0;
                m_combo = 0;
            end else if (m_phase == 1 && md == M_PLAY) begin
                if (ms) begin
                    m_combo = 0;
                end else if (h) begin
                    m_score = m_score + points(m_combo);
                    if (m_score > SCORE_MAX) m_score = SCORE_MAX;
                    if (m_combo < COMBO_MAX) m_combo = m_combo + 1;
                end
            end else if (m_phase == 1) begin
                m_phase = (md == M_FINISH) ? 2 : 0;
            end else if (m_phase == 2 && md != M_FINISH) begin
                m_phase = 0;
            end
        end
        e.score = m_score;
        e.combo = m_combo;
        e.done  = m_done;
        e.idx   = step_idx;
        exp_q.push_back(e);
    endtask

    task automatic step(input bit r, input logic [2:0] md, input bit h, input bit ms);
        @(negedge clk);
        rst  = r;
        mode = md;
        hit  = h;
        miss = ms;
        step_idx++;
        model_update(r, md, h, ms);
    endtask

    // Monitor: one expected entry per clock edge once stimulus has started.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (score !== SCORE_W'(e.score)) begin
                    miscompares++;
                    $display("FAIL score step %0d: got %0d expected %0d", e.idx, score, e.score);
                end
                vectors++;
                if (combo !== COMBO_W'(e.combo)) begin
                    miscompares++;
                    $display("FAIL combo step %0d: got %0d expected %0d", e.idx, combo, e.combo);
                end
                vectors++;
                if (score_done !== e.done) begin
                    miscompares++;
                    $display("FAIL score_done step %0d: got %0b expected %0b", e.idx, score_done, e.done);
                end
            end
        end
    end

    initial begin
        int wait_cycles;
        rst  = 1'b1;
        mode = M_PLAY;
        hit  = 1'b1;
        miss = 1'b0;

        // Reset held with PLAY and hit asserted.
        step(1, M_PLAY, 1, 0);
        step(1, M_PLAY, 1, 0);
        // Idle, enter PLAY, three hits with gaps.
        step(0, M_IDLE, 0, 0);
        step(0, M_PLAY, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, M_PLAY, 1, 0);
            step(0, M_PLAY, 0, 0);
        end
        // Saturation run, then a miss.
        for (int i = 0; i < 20; i++) step(0, M_PLAY, 1, 0);
        step(0, M_PLAY, 0, 1);
        step(0, M_PLAY, 0, 0);
        // Finish, hits ignored while finished, re-entry clears.
        step(0, M_FINISH, 0, 0);
        step(0, M_FINISH, 1, 0);
        step(0, M_FINISH, 1, 0);
        step(0, M_PLAY, 1, 0);
        step(0, M_PLAY, 1, 0);
        step(0, M_PLAY, 1, 0);
        step(0, M_PLAY, 1, 1);
        step(0, M_PLAY, 0, 0);
        step(0, M_IDLE, 1, 0);
        step(0, M_IDLE, 0, 0);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            int r;
            int hm;
            logic [2:0] md;
            r = $urandom_range(0, 9);
            if (r <= 5)      md = M_PLAY;
            else if (r <= 7) md = M_FINISH;
            else if (r == 8) md = M_IDLE;
            else             md = 3'($urandom_range(0, 7));
            hm = $urandom_range(0, 19);
            step(($urandom_range(0, 99) == 0), md, (hm < 8) || (hm == 19), (hm >= 16));
        end
        step(0, M_IDLE, 0, 0);

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
